calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
Controller for the 8-bit switch calculator datapath. It debounces and edge-detects the four user buttons and runs a small FSM that owns the accumulator: store, add, subtract and show. It produces the 8-bit value for the seven-segment nibble decoders and mux, plus a carry/borrow flag for the LEDs. It replaces level-sensitive button muxing and the negedge-clocked store register with one synchronous CLK domain.

Parameters:
DATA_W, 8, width of switch input, accumulator and display value.
DEBOUNCE_CYCLES, 50000, consecutive stable CLK cycles required before a debounced level changes (about 4 ms at 12 MHz); legal range 1 to 2^20-1.
SHOW_CYCLES, 12000000, CLK cycles the result is held on the display before it reverts to the switches; legal range 1 to 2^24-1.

Ports:
CLK  input  1  system clock; all state on rising edge.
RST  input  1  asynchronous, active-high reset.
btn_store  input  1  raw store button, active high (BTN_N inverted at top level); asynchronous to CLK.
btn_add  input  1  raw add button, active high.
btn_sub  input  1  raw subtract button, active high.
btn_show  input  1  raw show-accumulator button, active high.
sw  input  DATA_W  switch operand; treated as quasi-static and sampled directly.
acc  output  DATA_W  accumulator register.
carry  output  1  carry from the last add, or borrow from the last subtract.
disp_value  output  DATA_W  value to display: sw in IDLE, acc in EXEC and HOLD.
disp_src  output  1  0 = switches shown, 1 = accumulator shown.
busy  output  1  high only in EXEC.
state  output  2  IDLE=0, EXEC=1, HOLD=2; 3 is unused and recovers to IDLE on the next cycle.

Behaviour:
- Reset (async assert, sync release):
  - acc=0, carry=0, state=IDLE, timer=0.
  - Synchronizers, debounced levels and debounce counters all 0.
  - Outputs therefore: disp_value=sw, disp_src=0, busy=0.
- Per-button conditioning:
  - 2-flop synchronizer.
  - Debounce counter: counts while the synced level differs from the debounced level; clears to 0 whenever they match.
  - Debounced level flips when the counter reaches DEBOUNCE_CYCLES-1, i.e. after DEBOUNCE_CYCLES consecutive differing cycles.
  - A 0->1 flip of the debounced level yields a 1-cycle pulse. Release (1->0) yields no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Pulse priority within one cycle: store > sub > add > show. Lower-priority pulses in that same cycle are discarded.
- IDLE:
  - store pulse: acc<=sw, carry<=0 on that edge; next state HOLD.
  - add or sub pulse: latch op; next state EXEC.
  - show pulse: next state HOLD, acc unchanged.
  - No pulse: stay in IDLE.
- EXEC (exactly 1 cycle, busy=1):
  - add: {carry,acc} <= acc+sw using a DATA_W+1 bit sum; result wraps modulo 2^DATA_W.
  - sub: acc <= acc-sw modulo 2^DATA_W; carry <= (sw > acc) unsigned.
  - Next state HOLD.
  - Pulses arriving in the EXEC cycle are dropped.
- HOLD:
  - Timer starts at 0 on entry and increments each cycle; at SHOW_CYCLES-1 the next state is IDLE and the timer clears.
  - Any pulse in HOLD is handled exactly as in IDLE, and the timer restarts at 0. This allows chained operations without waiting.
- Latency:
  - Button stable high at sync output in cycle N -> pulse at N+DEBOUNCE_CYCLES.
  - add/sub pulse at cycle P -> acc and carry updated at edge P+2, EXEC visible during P+1.
  - store pulse at cycle P -> acc updated at edge P+1.
- disp_value and disp_src are combinational from state, acc and sw. sw changes in IDLE pass straight through.
- Wrap-around: 0xFF+0x01 -> acc=0x00, carry=1. 0x00-0x01 -> acc=0xFF, carry=1.
- RST asserted mid-EXEC or mid-HOLD: immediate return to reset values, with no partial acc update.

Test Plan:
Use DEBOUNCE_CYCLES=4 and SHOW_CYCLES=8 for all scenarios.
1. Reset: RST high, sw=0x3C -> acc=0, carry=0, state=0, disp_value=0x3C, busy=0. Then release RST, all buttons low, 50 cycles -> outputs unchanged.
2. Debounce: btn_add pulsed high for 3 cycles -> no state change. Held high 10 cycles -> exactly one EXEC cycle; acc updated once.
3. Store then add: sw=0xF0, store -> acc=0xF0, disp_value=0xF0 for 8 cycles, then disp_value=sw. Next sw=0x20, add -> acc=0x10, carry=1.
4. Subtract borrow: acc=0x05, sw=0x07, sub -> acc=0xFE, carry=1. Then sw=0x01, sub -> acc=0xFD, carry=0.
5. Simultaneous and chained: store and add debounced pulses in the same cycle with sw=0x11 -> store wins, acc=0x11, no EXEC. An add pulse at HOLD timer=5 -> EXEC, then HOLD with timer restarted, acc=0x22.
6. Reset mid-op: assert RST during the EXEC cycle of 0x10+0x10 -> acc=0x00, state=IDLE, carry=0. After release, no spurious pulse while buttons are still held high until they are re-pressed after release.

Source files
------------

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
// Controller for the 8-bit switch calculator. Synchronizes and debounces the
// four user buttons, turns debounced presses into one-cycle pulses and runs
// the IDLE/EXEC/HOLD sequencer that owns the accumulator (store, add,
// subtract, show). Everything runs in the single CLK domain.
//
// Ports
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset, released synchronously
//   btn_store   raw store button (active high, asynchronous)
//   btn_add     raw add button
//   btn_sub     raw subtract button
//   btn_show    raw show-accumulator button
//   sw          switch operand (quasi-static)
//   acc         accumulator register
//   carry       carry of the last add / borrow of the last subtract
//   disp_value  sw while idle, acc while executing or holding
//   disp_src    0 = switches shown, 1 = accumulator shown
//   busy        high during the single EXEC cycle
//   state       IDLE=0, EXEC=1, HOLD=2
// -----------------------------------------------------------------------------
module calc_sequencer #(
    parameter int DATA_W          = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SHOW_CYCLES     = 12000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              btn_store,
    input  logic              btn_add,
    input  logic              btn_sub,
    input  logic              btn_show,
    input  logic [DATA_W-1:0] sw,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic [DATA_W-1:0] disp_value,
    output logic              disp_src,
    output logic              busy,
    output logic [1:0]        state
);

    localparam int CNT_W = 20;
    localparam int TMR_W = 24;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);

    // Button vector bit positions
    localparam int B_STORE = 0;
    localparam int B_SUB   = 1;
    localparam int B_ADD   = 2;
    localparam int B_SHOW  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic [3:0]       btn_raw_s;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       db_q;
    logic [3:0]       armed_q;
    logic [3:0]       pulse_q;
    logic [3:0]       flip_s;
    logic [CNT_W-1:0] cnt_q [4];
    logic [1:0]       fill_q;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                carry_q, carry_d;
    logic                op_sub_q, op_sub_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [DATA_W:0]     sum_s;
    logic [DATA_W-1:0]   diff_s;
    logic                borrow_s;

    assign btn_raw_s = {btn_show, btn_add, btn_sub, btn_store};

    // Debounced level is about to change: synced level has differed long enough
    always_comb begin
        flip_s = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            if ((sync2_q[b] != db_q[b]) && (cnt_q[b] == DB_LAST)) begin
                flip_s[b] = 1'b1;
            end else begin
                flip_s[b] = 1'b0;
            end
        end
    end

    // Synchronizers, debounce counters, press pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            db_q    <= 4'b0000;
            armed_q <= 4'b0000;
            pulse_q <= 4'b0000;
            fill_q  <= 2'd0;
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            sync1_q <= btn_raw_s;
            sync2_q <= sync1_q;
            // Two edges after reset the synchronizer output reflects the pin
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            for (int b = 0; b < 4; b++) begin
                if (flip_s[b]) begin
                    db_q[b]  <= sync2_q[b];
                    cnt_q[b] <= '0;
                end else if (sync2_q[b] != db_q[b]) begin
                    cnt_q[b] <= cnt_q[b] + CNT_W'(1);
                end else begin
                    cnt_q[b] <= '0;
                end
                // A button held through reset must be seen released before
                // its next press is allowed to produce a pulse.
                if ((fill_q == 2'd2) && !sync2_q[b]) begin
                    armed_q[b] <= 1'b1;
                end
                pulse_q[b] <= flip_s[b] & sync2_q[b] & armed_q[b];
            end
        end
    end

    assign sum_s    = {1'b0, acc_q} + {1'b0, sw};
    assign diff_s   = acc_q - sw;
    assign borrow_s = (sw > acc_q);

    // Sequencer next state; pulses are accepted in IDLE and HOLD only
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        op_sub_d = op_sub_q;
        timer_d  = timer_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (pulse_q[B_STORE]) begin
                    acc_d   = sw;
                    carry_d = 1'b0;
                    state_d = ST_HOLD;
                    timer_d = '0;
                end else if (pulse_q[B_SUB]) begin
                    op_sub_d = 1'b1;
                    state_d  = ST_EXEC;
                    timer_d  = '0;
                end else if (pulse_q[B_ADD]) begin
                    op_sub_d = 1'b0;
                    state_d  = ST_EXEC;
                    timer_d  = '0;
                end else if (pulse_q[B_SHOW]) begin
                    state_d = ST_HOLD;
                    timer_d = '0;
                end else if (state_q == ST_HOLD) begin
                    if (timer_q == SHOW_LAST) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (op_sub_q) begin
                    acc_d   = diff_s;
                    carry_d = borrow_s;
                end else begin
                    acc_d   = sum_s[DATA_W-1:0];
                    carry_d = sum_s[DATA_W];
                end
                state_d = ST_HOLD;
                timer_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Sequencer state, accumulator and hold timer
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            op_sub_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            op_sub_q <= op_sub_d;
            timer_q  <= timer_d;
        end
    end

    // Display selection follows the state directly so switch moves show at once
    always_comb begin
        disp_src   = 1'b0;
        disp_value = sw;
        if ((state_q == ST_EXEC) || (state_q == ST_HOLD)) begin
            disp_src   = 1'b1;
            disp_value = acc_q;
        end else begin
            disp_src   = 1'b0;
            disp_value = sw;
        end
    end

    assign acc   = acc_q;
    assign carry = carry_q;
    assign busy  = (state_q == ST_EXEC);
    assign state = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

    localparam logic [3:0] M_STORE = 4'b0001;
    localparam logic [3:0] M_ADD   = 4'b0010;
    localparam logic [3:0] M_SUB   = 4'b0100;
    localparam logic [3:0] M_SHOW  = 4'b1000;

    logic       CLK = 1'b0;
    logic       RST;
    logic       btn_store, btn_add, btn_sub, btn_show;
    logic [7:0] sw;
    logic [7:0] acc;
    logic       carry;
    logic [7:0] disp_value;
    logic       disp_src;
    logic       busy;
    logic [1:0] state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model of the user-visible accumulator
    logic [7:0] m_acc;
    logic       m_carry;

    always #5 CLK = ~CLK;

    calc_sequencer #(
        .DATA_W(8),
        .DEBOUNCE_CYCLES(4),
        .SHOW_CYCLES(8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .btn_store(btn_store),
        .btn_add(btn_add),
        .btn_sub(btn_sub),
        .btn_show(btn_show),
        .sw(sw),
        .acc(acc),
        .carry(carry),
        .disp_value(disp_value),
        .disp_src(disp_src),
        .busy(busy),
        .state(state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_btns(input logic [3:0] m);
        btn_store = m[0];
        btn_add   = m[1];
        btn_sub   = m[2];
        btn_show  = m[3];
    endtask

    // Effect of one press (mask of simultaneous buttons) on the accumulator
    function automatic void model_op(input logic [3:0] m, input logic [7:0] s);
        int r;
        if (m[0]) begin
            m_acc   = s;
            m_carry = 1'b0;
        end else if (m[2]) begin
            r       = int'(m_acc) - int'(s);
            m_carry = (r < 0);
            m_acc   = 8'(r & 255);
        end else if (m[1]) begin
            r       = int'(m_acc) + int'(s);
            m_carry = (r > 255);
            m_acc   = 8'(r & 255);
        end
    endfunction

    task automatic press_until(input logic [3:0] m, input logic [1:0] target,
                               input bit release_after, output bit ok);
        ok = 1'b0;
        set_btns(m);
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge CLK);
            if (state == target) ok = 1'b1;
        end
        if (release_after) set_btns(4'b0000);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            if (state == 2'd0) ok = 1'b1;
        end
    endtask

    // One complete operation from IDLE back to IDLE
    task automatic do_op(input logic [3:0] m, input logic [7:0] s, output bit ok);
        bit ok1, ok2;
        logic [1:0] target;
        sw = s;
        if (m[0]) target = 2'd2;
        else if (m[1] || m[2]) target = 2'd1;
        else target = 2'd2;
        press_until(m, target, 1'b1, ok1);
        wait_idle(40, ok2);
        ok = ok1 && ok2;
    endtask

    task automatic test_reset();
        bit bad;
        RST = 1'b1;
        sw  = 8'h3C;
        set_btns(4'b0000);
        #23;
        total_cnt++; if (acc !== 8'h00) $display("FAIL reset_acc: got %h expected 00", acc); else pass_cnt++;
        total_cnt++; if (carry !== 1'b0) $display("FAIL reset_carry: got %b expected 0", carry); else pass_cnt++;
        total_cnt++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else pass_cnt++;
        total_cnt++; if (disp_value !== 8'h3C) $display("FAIL reset_disp: got %h expected 3c", disp_value); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (disp_src !== 1'b0) $display("FAIL reset_src: got %b expected 0", disp_src); else pass_cnt++;
        @(negedge CLK);
        RST = 1'b0;
        bad = 1'b0;
        repeat (50) begin
            @(negedge CLK);
            if (state !== 2'd0 || busy !== 1'b0 || disp_value !== 8'h3C || acc !== 8'h00) bad = 1'b1;
        end
        total_cnt++; if (bad) $display("FAIL reset_quiet: got disturbance=1 expected 0"); else pass_cnt++;
        m_acc   = 8'h00;
        m_carry = 1'b0;
    endtask

    task automatic test_debounce();
        bit seen;
        bit ok;
        int execs;
        sw = 8'h05;
        set_btns(M_ADD);
        repeat (3) @(negedge CLK);
        set_btns(4'b0000);
        seen = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (state !== 2'd0) seen = 1'b1;
        end
        total_cnt++; if (seen) $display("FAIL debounce_glitch: got state change expected none"); else pass_cnt++;
        set_btns(M_ADD);
        execs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (i == 10) set_btns(4'b0000);
            if (busy === 1'b1) execs++;
        end
        model_op(M_ADD, 8'h05);
        total_cnt++; if (execs != 1) $display("FAIL debounce_execs: got %0d expected 1", execs); else pass_cnt++;
        total_cnt++; if (acc !== m_acc) $display("FAIL debounce_acc: got %h expected %h", acc, m_acc); else pass_cnt++;
        wait_idle(40, ok);
        total_cnt++; if (!ok) $display("FAIL debounce_idle: got timeout expected IDLE"); else pass_cnt++;
    endtask

    task automatic test_store_add();
        bit ok;
        bit disp_ok;
        int hold_cnt;
        sw = 8'hF0;
        press_until(M_STORE, 2'd2, 1'b1, ok);
        model_op(M_STORE, 8'hF0);
        total_cnt++; if (!ok) $display("FAIL store_hold: got timeout expected HOLD"); else pass_cnt++;
        sw = 8'h20;
        hold_cnt = 0;
        disp_ok  = 1'b1;
        while (state == 2'd2 && hold_cnt < 20) begin
            if (disp_value !== m_acc || disp_src !== 1'b1) disp_ok = 1'b0;
            hold_cnt++;
            @(negedge CLK);
        end
        total_cnt++; if (hold_cnt != 8) $display("FAIL store_hold_len: got %0d expected 8", hold_cnt); else pass_cnt++;
        total_cnt++; if (!disp_ok) $display("FAIL store_hold_disp: got switch value expected acc %h", m_acc); else pass_cnt++;
        total_cnt++; if (disp_value !== 8'h20 || disp_src !== 1'b0) $display("FAIL store_revert: got %h/%b expected 20/0", disp_value, disp_src); else pass_cnt++;
        do_op(M_ADD, 8'h20, ok);
        model_op(M_ADD, 8'h20);
        total_cnt++; if (!ok) $display("FAIL add_timing: got timeout expected completion"); else pass_cnt++;
        total_cnt++; if (acc !== 8'h10 || acc !== m_acc) $display("FAIL add_acc: got %h expected 10", acc); else pass_cnt++;
        total_cnt++; if (carry !== 1'b1) $display("FAIL add_carry: got %b expected 1", carry); else pass_cnt++;
    endtask

    task automatic test_subtract();
        bit ok;
        do_op(M_STORE, 8'h05, ok); model_op(M_STORE, 8'h05);
        do_op(M_SUB, 8'h07, ok);   model_op(M_SUB, 8'h07);
        total_cnt++; if (!ok) $display("FAIL sub1_timing: got timeout expected completion"); else pass_cnt++;
        total_cnt++; if (acc !== 8'hFE || carry !== 1'b1) $display("FAIL sub1_result: got %h/%b expected fe/1", acc, carry); else pass_cnt++;
        do_op(M_SUB, 8'h01, ok);   model_op(M_SUB, 8'h01);
        total_cnt++; if (acc !== 8'hFD || carry !== 1'b0) $display("FAIL sub2_result: got %h/%b expected fd/0", acc, carry); else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit ok;
        do_op(M_STORE, 8'hFF, ok); model_op(M_STORE, 8'hFF);
        do_op(M_ADD, 8'h01, ok);   model_op(M_ADD, 8'h01);
        total_cnt++; if (acc !== 8'h00 || carry !== 1'b1) $display("FAIL wrap_add: got %h/%b expected 00/1", acc, carry); else pass_cnt++;
        do_op(M_STORE, 8'h00, ok); model_op(M_STORE, 8'h00);
        do_op(M_SUB, 8'h01, ok);   model_op(M_SUB, 8'h01);
        total_cnt++; if (acc !== 8'hFF || carry !== 1'b1) $display("FAIL wrap_sub: got %h/%b expected ff/1", acc, carry); else pass_cnt++;
    endtask

    task automatic test_simultaneous_chain();
        bit ok;
        int execs;
        int hold_cnt;
        sw    = 8'h11;
        execs = 0;
        ok    = 1'b0;
        set_btns(M_STORE | M_ADD);
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge CLK);
            if (busy === 1'b1) execs++;
            if (state == 2'd2) ok = 1'b1;
        end
        set_btns(4'b0000);
        model_op(M_STORE | M_ADD, 8'h11);
        total_cnt++; if (!ok) $display("FAIL simul_hold: got timeout expected HOLD"); else pass_cnt++;
        total_cnt++; if (execs != 0) $display("FAIL simul_exec: got %0d EXEC cycles expected 0", execs); else pass_cnt++;
        total_cnt++; if (acc !== m_acc) $display("FAIL simul_acc: got %h expected %h", acc, m_acc); else pass_cnt++;
        wait_idle(40, ok);
        // Show press at negedge s: HOLD entered (timer 0) at s+7; add pressed at
        // s+6 pulses at s+12, i.e. while the hold timer is 5.
        set_btns(M_SHOW);
        repeat (6) @(negedge CLK);
        set_btns(M_SHOW | M_ADD);
        @(negedge CLK);
        total_cnt++; if (state !== 2'd2) $display("FAIL chain_show: got %0d expected 2", state); else pass_cnt++;
        set_btns(M_ADD);
        repeat (5) @(negedge CLK);
        total_cnt++; if (state !== 2'd2) $display("FAIL chain_t5: got %0d expected 2", state); else pass_cnt++;
        @(negedge CLK);
        total_cnt++; if (state !== 2'd1 || busy !== 1'b1) $display("FAIL chain_exec: got %0d/%b expected 1/1", state, busy); else pass_cnt++;
        set_btns(4'b0000);
        model_op(M_ADD, 8'h11);
        @(negedge CLK);
        total_cnt++; if (acc !== m_acc || acc !== 8'h22) $display("FAIL chain_acc: got %h expected 22", acc); else pass_cnt++;
        hold_cnt = 0;
        while (state == 2'd2 && hold_cnt < 20) begin
            hold_cnt++;
            @(negedge CLK);
        end
        total_cnt++; if (hold_cnt != 8) $display("FAIL chain_restart: got %0d HOLD cycles expected 8", hold_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        bit seen;
        do_op(M_STORE, 8'h10, ok); model_op(M_STORE, 8'h10);
        ok = 1'b0;
        set_btns(M_ADD);
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge CLK);
            if (busy === 1'b1) ok = 1'b1;
        end
        total_cnt++; if (!ok) $display("FAIL rst_exec_reach: got timeout expected EXEC"); else pass_cnt++;
        RST = 1'b1;
        #1;
        m_acc   = 8'h00;
        m_carry = 1'b0;
        total_cnt++; if (acc !== m_acc || carry !== m_carry || state !== 2'd0) $display("FAIL rst_mid: got %h/%b/%0d expected 00/0/0", acc, carry, state); else pass_cnt++;
        repeat (3) @(negedge CLK);
        total_cnt++; if (acc !== 8'h00 || state !== 2'd0) $display("FAIL rst_held: got %h/%0d expected 00/0", acc, state); else pass_cnt++;
        RST  = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge CLK);
            if (state !== 2'd0) seen = 1'b1;
        end
        total_cnt++; if (seen) $display("FAIL rst_spurious: got activity expected none"); else pass_cnt++;
        set_btns(4'b0000);
        repeat (10) @(negedge CLK);
        do_op(M_ADD, 8'h10, ok); model_op(M_ADD, 8'h10);
        total_cnt++; if (!ok || acc !== m_acc || carry !== m_carry) $display("FAIL rst_repress: got %h/%b expected %h/%b", acc, carry, m_acc, m_carry); else pass_cnt++;
    endtask

    task automatic test_random_ops();
        bit ok;
        logic [3:0] m;
        logic [7:0] s;
        for (int i = 0; i < 14; i++) begin
            m = 4'($urandom_range(1, 15));
            s = 8'($urandom_range(0, 255));
            do_op(m, s, ok);
            model_op(m, s);
            total_cnt++;
            if (!ok || acc !== m_acc || carry !== m_carry || disp_value !== s)
                $display("FAIL random_op%0d: mask %b sw %h got acc %h carry %b disp %h expected %h %b %h",
                         i, m, s, acc, carry, disp_value, m_acc, m_carry, s);
            else pass_cnt++;
        end
    endtask

    initial begin
        RST = 1'b1;
        set_btns(4'b0000);
        sw = 8'h00;
        test_reset();
        test_debounce();
        test_store_add();
        test_subtract();
        test_wrap();
        test_simultaneous_chain();
        test_reset_mid_op();
        test_random_ops();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
